a_regwrite_arbiter: RTL and testbench

Owns the single register-file write port and shares it between the in-order writeback stage and the multi-cycle multiply/divide unit (MDU). Writeback results take priority; MDU results are bypassed when the port is free or queued in a small FIFO. A starvation guard stalls the pipeline so queued results drain. The block tracks pending MDU destinations for the hazard unit and sequences the final halt so it is raised only after every outstanding write has retired.

---
 rtl/a_regwrite_arbiter.sv | 167 ++++++++++++++++
 tb/tb_a_regwrite_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/a_regwrite_arbiter.sv
// Register-file write-port arbiter: writeback has priority, MDU results bypass or queue,
// a starvation guard drains the queue, and halt is raised only once all writes retire.
module a_regwrite_arbiter #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        wb_regwen,
  input  logic [4:0]  wb_rw,
  input  logic [31:0] wb_port_w,
  input  logic        wb_halt,
  input  logic        mdu_issue,
  input  logic [4:0]  mdu_issue_rw,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rw,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  output logic        rf_wen,
  output logic [4:0]  rf_wsel,
  output logic [31:0] rf_wdat,
  output logic        wb_stall,
  output logic [31:0] pend_mask,
  output logic        waw_err,
  output logic        halt
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OW = PW + 1;
  localparam int unsigned CW = $clog2(STARVE_MAX) + 1;
  localparam logic [OW-1:0] OCC_FULL    = OW'(DEPTH);
  localparam logic [CW-1:0] STARVE_LAST = CW'(STARVE_MAX - 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  logic [4:0]    fifo_rw  [DEPTH];
  logic [31:0]   fifo_dat [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [OW-1:0] occ;
  logic [CW-1:0] starve_cnt;
  logic [31:0]   pend_next;
  state_t        state;
  state_t        state_next;

  logic empty;
  logic full;
  logic wb_req;
  logic head_grant;
  logic bypass;
  logic mdu_take;
  logic mdu_zero;
  logic enq;
  logic drop;
  logic drained;

  assign empty     = (occ == '0);
  assign full      = (occ == OCC_FULL);
  assign mdu_ready = !full;
  assign wb_stall  = !empty && (starve_cnt == STARVE_LAST);

  // Grants are masked while in reset so the write port stays quiet regardless of inputs.
  assign wb_req     = !RST && wb_regwen && !wb_stall && (wb_rw != '0);
  assign head_grant = !RST && !wb_req && !empty;
  assign mdu_zero   = (mdu_rw == '0);
  assign mdu_take   = mdu_valid && !full;
  assign bypass     = !RST && !wb_req && empty && mdu_valid && !mdu_zero;
  assign enq        = mdu_take && !mdu_zero && !bypass;
  assign drop       = mdu_take && mdu_zero;
  assign drained    = empty && (pend_mask == '0) && !mdu_valid;
  assign halt       = (state == ST_HALTED);

  always_comb begin
    rf_wen  = 1'b0;
    rf_wsel = '0;
    rf_wdat = '0;
    if (wb_req) begin
      rf_wen  = 1'b1;
      rf_wsel = wb_rw;
      rf_wdat = wb_port_w;
    end else if (head_grant) begin
      rf_wen  = 1'b1;
      rf_wsel = fifo_rw[rd_ptr];
      rf_wdat = fifo_dat[rd_ptr];
    end else if (bypass) begin
      rf_wen  = 1'b1;
      rf_wsel = mdu_rw;
      rf_wdat = mdu_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (enq) begin
      fifo_rw[wr_ptr]  <= mdu_rw;
      fifo_dat[wr_ptr] <= mdu_data;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (enq)        wr_ptr <= wr_ptr + PW'(1);
      if (head_grant) rd_ptr <= rd_ptr + PW'(1);
      case ({enq, head_grant})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      starve_cnt <= '0;
    end else if (empty || head_grant) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_LAST) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

  // Clears are applied before the issue set so a same-register collision leaves the bit set.
  always_comb begin
    pend_next = pend_mask;
    if (head_grant) pend_next[fifo_rw[rd_ptr]] = 1'b0;
    else if (bypass) pend_next[mdu_rw] = 1'b0;
    if (drop) pend_next[0] = 1'b0;
    if (mdu_issue && (mdu_issue_rw != '0)) pend_next[mdu_issue_rw] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend_mask <= '0;
      waw_err   <= 1'b0;
    end else begin
      pend_mask <= pend_next;
      if (wb_req && pend_mask[wb_rw]) waw_err <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN: begin
        if (wb_halt && !wb_stall) state_next = drained ? ST_HALTED : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drained) state_next = ST_HALTED;
      end
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_RUN;
    else     state <= state_next;
  end

endmodule

// File: tb/tb_a_regwrite_arbiter.sv
// Self-checking bench for a_regwrite_arbiter: per-cycle vector table with an expected-result
// queue, plus hand sequences for reset-during-queue and direct halt.
module tb_a_regwrite_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        wb_regwen;
  logic [4:0]  wb_rw;
  logic [31:0] wb_port_w;
  logic        wb_halt;
  logic        mdu_issue;
  logic [4:0]  mdu_issue_rw;
  logic        mdu_valid;
  logic [4:0]  mdu_rw;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        rf_wen;
  logic [4:0]  rf_wsel;
  logic [31:0] rf_wdat;
  logic        wb_stall;
  logic [31:0] pend_mask;
  logic        waw_err;
  logic        halt;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  a_regwrite_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .CLK(CLK), .RST(RST),
    .wb_regwen(wb_regwen), .wb_rw(wb_rw), .wb_port_w(wb_port_w), .wb_halt(wb_halt),
    .mdu_issue(mdu_issue), .mdu_issue_rw(mdu_issue_rw),
    .mdu_valid(mdu_valid), .mdu_rw(mdu_rw), .mdu_data(mdu_data),
    .mdu_ready(mdu_ready), .rf_wen(rf_wen), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat),
    .wb_stall(wb_stall), .pend_mask(pend_mask), .waw_err(waw_err), .halt(halt)
  );

  typedef struct {
    logic        regwen;
    logic [4:0]  rw;
    logic [31:0] wdat;
    logic        whalt;
    logic        iss;
    logic [4:0]  irw;
    logic        mv;
    logic [4:0]  mrw;
    logic [31:0] mdat;
  } stim_t;

  typedef struct {
    logic        wen;
    logic [4:0]  sel;
    logic [31:0] dat;
    logic        stall;
    logic        ready;
    logic [31:0] pend;
    logic        waw;
    logic        hlt;
  } resp_t;

  typedef struct {
    stim_t s;
    resp_t e;
  } vec_t;

  vec_t  vecs[$];
  resp_t exp_q[$];

  function automatic vec_t mk(
    input logic regwen, input logic [4:0] rw, input logic [31:0] wdat, input logic whalt,
    input logic iss, input logic [4:0] irw,
    input logic mv, input logic [4:0] mrw, input logic [31:0] mdat,
    input logic wen, input logic [4:0] sel, input logic [31:0] dat,
    input logic stall, input logic ready, input logic [31:0] pend, input logic waw, input logic hlt);
    vec_t v;
    v.s = '{regwen, rw, wdat, whalt, iss, irw, mv, mrw, mdat};
    v.e = '{wen, sel, dat, stall, ready, pend, waw, hlt};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input stim_t s);
    wb_regwen    = s.regwen;
    wb_rw        = s.rw;
    wb_port_w    = s.wdat;
    wb_halt      = s.whalt;
    mdu_issue    = s.iss;
    mdu_issue_rw = s.irw;
    mdu_valid    = s.mv;
    mdu_rw       = s.mrw;
    mdu_data     = s.mdat;
  endtask

  task automatic idle();
    stim_t s;
    s = '{1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0};
    drive(s);
  endtask

  task automatic check_resp(input string tag, input resp_t e);
    chk({tag, ".rf_wen"},    32'(rf_wen),    32'(e.wen));
    chk({tag, ".rf_wsel"},   32'(rf_wsel),   32'(e.sel));
    chk({tag, ".rf_wdat"},   rf_wdat,        e.dat);
    chk({tag, ".wb_stall"},  32'(wb_stall),  32'(e.stall));
    chk({tag, ".mdu_ready"}, 32'(mdu_ready), 32'(e.ready));
    chk({tag, ".pend_mask"}, pend_mask,      e.pend);
    chk({tag, ".waw_err"},   32'(waw_err),   32'(e.waw));
    chk({tag, ".halt"},      32'(halt),      32'(e.hlt));
  endtask

  initial begin
    // Columns: regwen rw wdat whalt | iss irw | mv mrw mdat || wen sel dat stall ready pend waw halt
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0,0,               0,0,0,            0,1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,5, 0,0,0,               0,0,0,            0,1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0, 1,5,32'hDEADBEEF,    1,5,32'hDEADBEEF, 0,1,32'h20,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0,0,               0,0,0,            0,1,0,0,0));
    vecs.push_back(mk(1,0,32'h1234,0, 0,0, 0,0,0,        0,0,0,            0,1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0, 1,0,32'h55,          0,0,0,            0,1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0,0,               0,0,0,            0,1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,8, 0,0,0,               0,0,0,            0,1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,9, 0,0,0,               0,0,0,            0,1,32'h100,0,0));
    vecs.push_back(mk(0,0,0,0, 1,10, 0,0,0,              0,0,0,            0,1,32'h300,0,0));
    vecs.push_back(mk(1,1,32'h11,0, 0,0, 1,8,32'h88,     1,1,32'h11,       0,1,32'h700,0,0));
    vecs.push_back(mk(1,1,32'h12,0, 0,0, 1,9,32'h99,     1,1,32'h12,       0,1,32'h700,0,0));
    vecs.push_back(mk(1,1,32'h13,0, 0,0, 1,10,32'hAA,    1,1,32'h13,       0,0,32'h700,0,0));
    vecs.push_back(mk(1,1,32'h14,0, 0,0, 1,10,32'hAA,    1,1,32'h14,       0,0,32'h700,0,0));
    vecs.push_back(mk(1,1,32'h15,0, 0,0, 1,10,32'hAA,    1,8,32'h88,       1,0,32'h700,0,0));
    vecs.push_back(mk(1,1,32'h16,0, 0,0, 1,10,32'hAA,    1,1,32'h16,       0,1,32'h600,0,0));
    vecs.push_back(mk(1,1,32'h17,0, 0,0, 0,0,0,          1,1,32'h17,       0,0,32'h600,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0,0,               1,9,32'h99,       0,0,32'h600,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0,0,               1,10,32'hAA,      0,1,32'h400,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0,0,               0,0,0,            0,1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,7, 0,0,0,               0,0,0,            0,1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,7, 1,7,32'h77,          1,7,32'h77,       0,1,32'h80,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0,0,               0,0,0,            0,1,32'h80,0,0));
    vecs.push_back(mk(1,7,32'h70,0, 0,0, 0,0,0,          1,7,32'h70,       0,1,32'h80,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0,0,               0,0,0,            0,1,32'h80,1,0));
    vecs.push_back(mk(0,0,0,0, 0,0, 1,7,32'h71,          1,7,32'h71,       0,1,32'h80,1,0));
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0,0,               0,0,0,            0,1,0,1,0));
    vecs.push_back(mk(0,0,0,0, 1,3, 0,0,0,               0,0,0,            0,1,0,1,0));
    vecs.push_back(mk(1,2,32'h22,0, 0,0, 1,3,32'h33,     1,2,32'h22,       0,1,32'h8,1,0));
    vecs.push_back(mk(1,2,32'h23,1, 0,0, 0,0,0,          1,2,32'h23,       0,1,32'h8,1,0));
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0,0,               1,3,32'h33,       0,1,32'h8,1,0));
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0,0,               0,0,0,            0,1,0,1,0));
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0,0,               0,0,0,            0,1,0,1,1));
    vecs.push_back(mk(1,4,32'h44,0, 0,0, 0,0,0,          1,4,32'h44,       0,1,0,1,1));
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0,0,               0,0,0,            0,1,0,1,1));

    // Reset asserted mid-cycle with a write request present: port must stay quiet.
    RST = 1'b0;
    idle();
    #3;
    RST = 1'b1;
    wb_regwen = 1'b1;
    wb_rw     = 5'd3;
    wb_port_w = 32'hCAFE;
    #1;
    chk("rst.rf_wen", 32'(rf_wen), 32'd0);
    chk("rst.rf_wdat", rf_wdat, 32'd0);
    chk("rst.mdu_ready", 32'(mdu_ready), 32'd1);
    chk("rst.pend_mask", pend_mask, 32'd0);
    chk("rst.halt", 32'(halt), 32'd0);
    @(negedge CLK);
    idle();
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      drive(vecs[i].s);
      exp_q.push_back(vecs[i].e);
      #2;
      check_resp($sformatf("v%0d", i), exp_q.pop_front());
    end

    // Two results queued, then reset lands before the second can retire.
    @(negedge CLK);
    idle();
    wb_regwen = 1'b1; wb_rw = 5'd1; wb_port_w = 32'h31;
    mdu_valid = 1'b1; mdu_rw = 5'd6; mdu_data = 32'h66;
    @(negedge CLK);
    wb_port_w = 32'h32; mdu_rw = 5'd11; mdu_data = 32'hBB;
    #2;
    chk("rq.wb_wsel", 32'(rf_wsel), 32'd1);
    @(negedge CLK);
    idle();
    #2;
    chk("rq.head_wsel", 32'(rf_wsel), 32'd6);
    chk("rq.head_wdat", rf_wdat, 32'h66);
    chk("rq.full_ready", 32'(mdu_ready), 32'd0);
    #1;
    RST = 1'b1;
    #1;
    chk("rq.rst_wen", 32'(rf_wen), 32'd0);
    chk("rq.rst_ready", 32'(mdu_ready), 32'd1);
    chk("rq.rst_halt", 32'(halt), 32'd0);
    chk("rq.rst_waw", 32'(waw_err), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    #2;
    chk("rq.after_wen", 32'(rf_wen), 32'd0);
    chk("rq.after_ready", 32'(mdu_ready), 32'd1);

    // Halt with nothing outstanding goes straight to HALTED.
    @(negedge CLK);
    wb_halt = 1'b1;
    #2;
    chk("dh.halt_before", 32'(halt), 32'd0);
    @(negedge CLK);
    wb_halt = 1'b0;
    #2;
    chk("dh.halt_after", 32'(halt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
